// File: rtl/ast_width_extender.sv
// Avalon-ST width extender: packs consecutive narrow beats of a packet into wide beats,
// carrying sop/eop, channel and empty across the width change.
module ast_width_extender #(
  parameter int DATA_IN_W   = 64,
  parameter int EMPTY_IN_W  = (DATA_IN_W / 8 > 1) ? $clog2(DATA_IN_W / 8) : 1,
  parameter int CHANNEL_W   = 10,
  parameter int DATA_OUT_W  = 256,
  parameter int EMPTY_OUT_W = (DATA_OUT_W / 8 > 1) ? $clog2(DATA_OUT_W / 8) : 1
) (
  input  logic                   clk_i,
  input  logic                   srst_i,
  input  logic [DATA_IN_W-1:0]   ast_data_i,
  input  logic                   ast_startofpacket_i,
  input  logic                   ast_endofpacket_i,
  input  logic                   ast_valid_i,
  input  logic [EMPTY_IN_W-1:0]  ast_empty_i,
  input  logic [CHANNEL_W-1:0]   ast_channel_i,
  output logic                   ast_ready_o,
  output logic [DATA_OUT_W-1:0]  ast_data_o,
  output logic                   ast_startofpacket_o,
  output logic                   ast_endofpacket_o,
  output logic                   ast_valid_o,
  output logic [EMPTY_OUT_W-1:0] ast_empty_o,
  output logic [CHANNEL_W-1:0]   ast_channel_o,
  input  logic                   ast_ready_i
);

  localparam int K        = DATA_OUT_W / DATA_IN_W;
  localparam int IDX_W    = (K > 1) ? $clog2(K) : 1;
  localparam int BYTES_IN = DATA_IN_W / 8;

  logic [IDX_W-1:0]       idx_q;
  logic [IDX_W-1:0]       eff_idx;
  logic [DATA_OUT_W-1:0]  acc_q;
  logic [DATA_OUT_W-1:0]  acc_next;
  logic                   pending_sop_q;
  logic                   sop_next;
  logic [CHANNEL_W-1:0]   chan_q;
  logic [CHANNEL_W-1:0]   chan_next;
  logic [EMPTY_OUT_W-1:0] empty_next;
  logic                   in_fire;
  logic                   flush;

  // The output register may be reloaded in the same cycle it drains.
  assign ast_ready_o = !srst_i && (!ast_valid_o || ast_ready_i);
  assign in_fire     = ast_valid_i && ast_ready_o;

  always_comb begin
    // NOTE: every signal gets a value before any conditional logic, so no latch is inferred.
    eff_idx    = ast_startofpacket_i ? '0 : idx_q;
    acc_next   = ast_startofpacket_i ? '0 : acc_q;
    acc_next[eff_idx*DATA_IN_W +: DATA_IN_W] = ast_data_i;
    sop_next   = ast_startofpacket_i || pending_sop_q;
    chan_next  = ast_startofpacket_i ? ast_channel_i : chan_q;
    flush      = ast_endofpacket_i || (eff_idx == IDX_W'(K - 1));
    empty_next = '0;
    if (ast_endofpacket_i)
      empty_next = EMPTY_OUT_W'((K - 1 - int'(eff_idx)) * BYTES_IN + int'(ast_empty_i));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      // NOTE: the accumulator is reset too, because a reset mid-packet must not leak partial data.
      idx_q               <= '0;
      acc_q               <= '0;
      pending_sop_q       <= 1'b0;
      chan_q              <= '0;
      ast_valid_o         <= 1'b0;
      ast_startofpacket_o <= 1'b0;
      ast_endofpacket_o   <= 1'b0;
      ast_data_o          <= '0;
      ast_empty_o         <= '0;
      ast_channel_o       <= '0;
    end else begin
      if (in_fire) begin
        chan_q <= chan_next;
        if (flush) begin
          idx_q         <= '0;
          acc_q         <= '0;
          pending_sop_q <= 1'b0;
        end else begin
          idx_q         <= eff_idx + 1'b1;
          acc_q         <= acc_next;
          pending_sop_q <= sop_next;
        end
      end

      if (in_fire && flush) begin
        ast_valid_o         <= 1'b1;
        ast_data_o          <= acc_next;
        ast_startofpacket_o <= sop_next;
        ast_endofpacket_o   <= ast_endofpacket_i;
        ast_empty_o         <= empty_next;
        ast_channel_o       <= chan_next;
      end else if (ast_ready_i) begin
        ast_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ast_width_extender.sv
// Scoreboard bench for ast_width_extender at 64 -> 256 bits: expected wide beats are
// queued when packets are driven and compared as the DUT presents them.
module tb_ast_width_extender;

  localparam int DIW = 64;
  localparam int DOW = 256;
  localparam int K   = 4;
  localparam int CW  = 10;
  localparam int EIW = 3;
  localparam int EOW = 5;

  logic           clk_i = 1'b0;
  logic           srst_i = 1'b1;
  logic [DIW-1:0] ast_data_i = '0;
  logic           ast_startofpacket_i = 1'b0;
  logic           ast_endofpacket_i = 1'b0;
  logic           ast_valid_i = 1'b0;
  logic [EIW-1:0] ast_empty_i = '0;
  logic [CW-1:0]  ast_channel_i = '0;
  logic           ast_ready_o;
  logic [DOW-1:0] ast_data_o;
  logic           ast_startofpacket_o;
  logic           ast_endofpacket_o;
  logic           ast_valid_o;
  logic [EOW-1:0] ast_empty_o;
  logic [CW-1:0]  ast_channel_o;
  logic           ast_ready_i = 1'b1;

  typedef struct packed {
    logic [DOW-1:0] data;
    logic           sop;
    logic           eop;
    logic [EOW-1:0] empty;
    logic [CW-1:0]  chan;
  } beat_t;

  beat_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  ast_width_extender #(
    .DATA_IN_W  (DIW),
    .EMPTY_IN_W (EIW),
    .CHANNEL_W  (CW),
    .DATA_OUT_W (DOW),
    .EMPTY_OUT_W(EOW)
  ) dut (
    .clk_i              (clk_i),
    .srst_i             (srst_i),
    .ast_data_i         (ast_data_i),
    .ast_startofpacket_i(ast_startofpacket_i),
    .ast_endofpacket_i  (ast_endofpacket_i),
    .ast_valid_i        (ast_valid_i),
    .ast_empty_i        (ast_empty_i),
    .ast_channel_i      (ast_channel_i),
    .ast_ready_o        (ast_ready_o),
    .ast_data_o         (ast_data_o),
    .ast_startofpacket_o(ast_startofpacket_o),
    .ast_endofpacket_o  (ast_endofpacket_o),
    .ast_valid_o        (ast_valid_o),
    .ast_empty_o        (ast_empty_o),
    .ast_channel_o      (ast_channel_o),
    .ast_ready_i        (ast_ready_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, sb entries left=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  // Output monitor: compares every presented beat (including each stalled cycle) with the queue head.
  always @(negedge clk_i) begin
    if (ast_valid_o === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected: got data=%h sop=%b eop=%b empty=%0d chan=%0d, expected no beat",
                 ast_data_o, ast_startofpacket_o, ast_endofpacket_o, ast_empty_o, ast_channel_o);
      end else begin
        if (ast_data_o !== sb[0].data || ast_startofpacket_o !== sb[0].sop ||
            ast_endofpacket_o !== sb[0].eop || ast_empty_o !== sb[0].empty ||
            ast_channel_o !== sb[0].chan) begin
          n_fail++;
          $display("FAIL out_beat: got data=%h sop=%b eop=%b empty=%0d chan=%0d, expected data=%h sop=%b eop=%b empty=%0d chan=%0d",
                   ast_data_o, ast_startofpacket_o, ast_endofpacket_o, ast_empty_o, ast_channel_o,
                   sb[0].data, sb[0].sop, sb[0].eop, sb[0].empty, sb[0].chan);
        end
        if (ast_ready_i) void'(sb.pop_front());
      end
    end
  end

  task automatic drive_beat(input logic [DIW-1:0] d, input logic sop, input logic eop,
                            input logic [EIW-1:0] emp, input logic [CW-1:0] ch);
    int t;
    ast_data_i          = d;
    ast_startofpacket_i = sop;
    ast_endofpacket_i   = eop;
    ast_empty_i         = emp;
    ast_channel_i       = ch;
    ast_valid_i         = 1'b1;
    t = 0;
    @(negedge clk_i);
    while (ast_ready_o !== 1'b1 && t < 200) begin
      @(negedge clk_i);
      t++;
    end
    if (ast_ready_o !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: ready_o=%b after %0d cycles, expected 1", ast_ready_o, t);
    end
    @(posedge clk_i);
    #1;
    ast_valid_i         = 1'b0;
    ast_startofpacket_i = 1'b0;
    ast_endofpacket_i   = 1'b0;
  endtask

  // Builds expected wide beats for a packet of n random narrow beats, queues them, then drives the beats.
  task automatic send_packet(input logic [CW-1:0] chan, input int n,
                             input logic [EIW-1:0] last_empty, input bit has_sop);
    logic [DIW-1:0] beats[$];
    beat_t e;
    int ngroups;
    for (int i = 0; i < n; i++) beats.push_back({$urandom, $urandom});
    ngroups = (n + K - 1) / K;
    for (int g = 0; g < ngroups; g++) begin
      int nb;
      nb     = (g == ngroups - 1) ? n - g * K : K;
      e.data = '0;
      for (int j = 0; j < nb; j++) e.data[j*DIW +: DIW] = beats[g*K + j];
      e.sop   = has_sop && (g == 0);
      e.eop   = (g == ngroups - 1);
      e.empty = e.eop ? EOW'((K - nb) * (DIW / 8) + int'(last_empty)) : '0;
      e.chan  = chan;
      sb.push_back(e);
    end
    for (int i = 0; i < n; i++)
      drive_beat(beats[i], has_sop && (i == 0), i == n - 1,
                 (i == n - 1) ? last_empty : EIW'($urandom),
                 (i == 0) ? chan : CW'($urandom));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || ast_valid_o === 1'b1) && t < 100) begin
      @(negedge clk_i);
      t++;
    end
    n_checks++;
    if (sb.size() != 0 || ast_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: %0d beats still expected, valid_o=%b, expected 0 and 0", sb.size(), ast_valid_o);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    srst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    n_checks++;
    if ({ast_valid_o, ast_startofpacket_o, ast_endofpacket_o} !== 3'b000 || ast_data_o !== '0 ||
        ast_empty_o !== '0 || ast_channel_o !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b sop=%b eop=%b data=%h empty=%0d chan=%0d, expected all 0",
               ast_valid_o, ast_startofpacket_o, ast_endofpacket_o, ast_data_o, ast_empty_o, ast_channel_o);
    end
    n_checks++;
    if (ast_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: got %b, expected 0", ast_ready_o);
    end
    @(posedge clk_i);
    #1 srst_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (ast_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: got %b, expected 1", ast_ready_o);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_basic();
    ast_ready_i = 1'b1;
    send_packet(10'd5, 4, 3'd0, 1'b1);
    @(negedge clk_i);
    n_checks++;
    if (ast_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL latency: valid_o=%b one cycle after last beat, expected 1", ast_valid_o);
    end
    drain();
  endtask

  task automatic test_partial();
    send_packet(10'd7, 5, 3'd3, 1'b1);
    drain();
    send_packet(10'd9, 1, 3'd7, 1'b1);
    drain();
  endtask

  task automatic test_backpressure();
    ast_ready_i = 1'b0;
    fork
      begin
        send_packet(10'd11, 4, 3'd0, 1'b1);
        send_packet(10'd12, 8, 3'd5, 1'b1);
      end
      begin
        int t;
        t = 0;
        while (ast_valid_o !== 1'b1 && t < 100) begin
          @(negedge clk_i);
          t++;
        end
        for (int c = 0; c < 10; c++) begin
          @(negedge clk_i);
          n_checks++;
          if (ast_ready_o !== 1'b0 || ast_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_cycle%0d: ready_o=%b valid_o=%b, expected 0 and 1", c, ast_ready_o, ast_valid_o);
          end
        end
        @(posedge clk_i);
        #1 ast_ready_i = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_back_to_back();
    time t0;
    ast_ready_i = 1'b1;
    t0 = $time;
    send_packet(10'd1, 8, 3'd0, 1'b1);
    send_packet(10'd2, 8, 3'd1, 1'b1);
    n_checks++;
    if (($time - t0) / 10 != 16) begin
      n_fail++;
      $display("FAIL full_rate: 16 beats took %0d cycles, expected 16", ($time - t0) / 10);
    end
    drain();
  endtask

  task automatic test_reset_midpacket();
    drive_beat({$urandom, $urandom}, 1'b1, 1'b0, 3'd0, 10'd0);
    drive_beat({$urandom, $urandom}, 1'b0, 1'b0, 3'd0, 10'd0);
    srst_i = 1'b1;
    @(negedge clk_i);
    n_checks++;
    if (ast_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_ready: got %b, expected 0", ast_ready_o);
    end
    @(negedge clk_i);
    n_checks++;
    if ({ast_valid_o, ast_startofpacket_o, ast_endofpacket_o} !== 3'b000 || ast_data_o !== '0 ||
        ast_empty_o !== '0 || ast_channel_o !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got valid=%b sop=%b eop=%b data=%h empty=%0d chan=%0d, expected all 0",
               ast_valid_o, ast_startofpacket_o, ast_endofpacket_o, ast_data_o, ast_empty_o, ast_channel_o);
    end
    @(posedge clk_i);
    #1 srst_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (ast_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_release_ready: got %b, expected 1", ast_ready_o);
    end
    @(posedge clk_i);
    #1;
    // A lone eop beat without sop must land in slot 0 with sop=0 if idx/pending_sop were cleared.
    send_packet(10'd0, 1, 3'd2, 1'b0);
    drain();
    send_packet(10'd3, 4, 3'd0, 1'b1);
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_backpressure();
    test_back_to_back();
    test_reset_midpacket();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
